// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro DIVIDER_SIGNED_EN selects two's-complement operands with a sign fix-up state.
module restoring_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
      $error("restoring_divider: WIDTH must be a multiple of 4 and >= 4");
   end

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   // Handshake: a transfer happens on an edge where valid and ready are both 1.
   state_t           state;
   logic [WIDTH-1:0] rem_r;   // partial remainder; always < divisor so WIDTH bits suffice
   logic [WIDTH-1:0] dvd_r;   // dividend bits shift out at the top, quotient bits enter at the bottom
   logic [WIDTH-1:0] dvs_r;
   logic [CW-1:0]    count;
`ifdef DIVIDER_SIGNED_EN
   logic             neg_q;
   logic             neg_r;
`endif

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   b_inv;
   logic [WIDTH:0]   p;
   logic [WIDTH:0]   g;
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] t_sum;
   logic             cout;
   int               b0;

   // Trial subtraction R' - divisor as R' + ~divisor + 1 using 4-bit lookahead groups.
   always_comb begin
      r_shift = {rem_r, dvd_r[WIDTH-1]};
      b_inv   = ~{1'b0, dvs_r};
      p       = r_shift ^ b_inv;
      g       = r_shift & b_inv;
      carry   = '0;
      carry[0] = 1'b1;
      b0      = 0;
      for (int k = 0; k < WIDTH / 4; k++) begin
         b0 = 4 * k;
         carry[b0+1] = g[b0] | (p[b0] & carry[b0]);
         carry[b0+2] = g[b0+1] | (p[b0+1] & g[b0]) | (p[b0+1] & p[b0] & carry[b0]);
         carry[b0+3] = g[b0+2] | (p[b0+2] & g[b0+1]) | (p[b0+2] & p[b0+1] & g[b0])
                     | (p[b0+2] & p[b0+1] & p[b0] & carry[b0]);
         carry[b0+4] = g[b0+3] | (p[b0+3] & g[b0+2]) | (p[b0+3] & p[b0+2] & g[b0+1])
                     | (p[b0+3] & p[b0+2] & p[b0+1] & g[b0])
                     | (p[b0+3] & p[b0+2] & p[b0+1] & p[b0] & carry[b0]);
      end
      t_sum = p[WIDTH-1:0] ^ carry[WIDTH-1:0];
      cout  = g[WIDTH] | (p[WIDTH] & carry[WIDTH]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         rem_r       <= '0;
         dvd_r       <= '0;
         dvs_r       <= '0;
         count       <= '0;
`ifdef DIVIDER_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (divisor == '0) begin
                     state       <= DONE;
                     out_valid   <= 1'b1;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state       <= CALC;
                     rem_r       <= '0;
                     count       <= LAST;
                     div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                     dvd_r <= dividend[WIDTH-1] ? -dividend : dividend;
                     dvs_r <= divisor[WIDTH-1] ? -divisor : divisor;
                     neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     neg_r <= dividend[WIDTH-1];
`else
                     dvd_r <= dividend;
                     dvs_r <= divisor;
`endif
                  end
               end
            end
            CALC: begin
               rem_r <= cout ? t_sum : r_shift[WIDTH-1:0];
               dvd_r <= {dvd_r[WIDTH-2:0], cout};
               if (count == '0) begin
`ifdef DIVIDER_SIGNED_EN
                  state <= FIXUP;
`else
                  state     <= DONE;
                  out_valid <= 1'b1;
                  quotient  <= {dvd_r[WIDTH-2:0], cout};
                  remainder <= cout ? t_sum : r_shift[WIDTH-1:0];
`endif
               end else begin
                  count <= count - 1'b1;
               end
            end
`ifdef DIVIDER_SIGNED_EN
            FIXUP: begin
               state     <= DONE;
               out_valid <= 1'b1;
               quotient  <= neg_q ? -dvd_r : dvd_r;
               remainder <= neg_r ? -rem_r : rem_r;
            end
`endif
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider (WIDTH=16); follows DIVIDER_SIGNED_EN if defined.
module tb_restoring_divider;

   localparam int WIDTH = 16;
`ifdef DIVIDER_SIGNED_EN
   localparam int LAT = WIDTH + 2;
`else
   localparam int LAT = WIDTH + 1;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   restoring_divider #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   // Driver: present operands for one edge (the accept edge), then drop in_valid.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Edges counted include the accept edge; busy counts cycles where in_ready was wrongly high.
   task automatic wait_result(output int edges, output int busy);
      edges = 1;
      busy  = 0;
      while (!out_valid && edges < 200) begin
         if (in_ready) busy++;
         @(posedge clk);
         #1;
         edges++;
      end
      if (in_ready) busy++;
   endtask

   task automatic take();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
      #12;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (quotient !== 16'h0) begin errors++; $display("FAIL reset_quotient got %h want 0000", quotient); end
      checks++; if (remainder !== 16'h0) begin errors++; $display("FAIL reset_remainder got %h want 0000", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int edges, busy;
      send(16'd100, 16'd7);
      wait_result(edges, busy);
      checks++; if (edges != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", edges, LAT); end
      checks++; if (quotient !== 16'd14) begin errors++; $display("FAIL basic_q got %0d want 14", quotient); end
      checks++; if (remainder !== 16'd2) begin errors++; $display("FAIL basic_r got %0d want 2", remainder); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", div_by_zero); end
      take();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_release_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_release_ready got %b want 1", in_ready); end
   endtask

   task automatic test_boundaries();
      logic [WIDTH-1:0] vec [5][4] = '{
         '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000},
         '{16'h0003, 16'h0010, 16'h0000, 16'h0003},
         '{16'h2345, 16'h2345, 16'h0001, 16'h0000},
         '{16'h0000, 16'h0005, 16'h0000, 16'h0000},
         '{16'h7FFF, 16'h0100, 16'h007F, 16'h00FF}
      };
      int edges, busy;
      for (int i = 0; i < 5; i++) begin
         send(vec[i][0], vec[i][1]);
         wait_result(edges, busy);
         checks++; if (edges != LAT) begin errors++; $display("FAIL bound%0d_latency got %0d want %0d", i, edges, LAT); end
         checks++; if (quotient !== vec[i][2]) begin errors++; $display("FAIL bound%0d_q got %h want %h", i, quotient, vec[i][2]); end
         checks++; if (remainder !== vec[i][3]) begin errors++; $display("FAIL bound%0d_r got %h want %h", i, remainder, vec[i][3]); end
         checks++; if (busy != 0) begin errors++; $display("FAIL bound%0d_in_ready_busy got %0d want 0", i, busy); end
         take();
      end
   endtask

   task automatic test_div_zero();
      int edges, busy;
      send(16'h1234, 16'h0000);
      wait_result(edges, busy);
      checks++; if (edges != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", edges); end
      checks++; if (quotient !== 16'hFFFF) begin errors++; $display("FAIL dz_q got %h want ffff", quotient); end
      checks++; if (remainder !== 16'h1234) begin errors++; $display("FAIL dz_r got %h want 1234", remainder); end
      checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
      take();
   endtask

   task automatic test_backpressure();
      int edges, busy;
      send(16'd1000, 16'd33);
      // Busy-time operand changes and in_valid must be ignored.
      @(negedge clk);
      dividend = 16'd7; divisor = 16'd0; in_valid = 1'b1;
      wait_result(edges, busy);
      checks++; if (quotient !== 16'd30) begin errors++; $display("FAIL bp_q got %0d want 30", quotient); end
      checks++; if (remainder !== 16'd10) begin errors++; $display("FAIL bp_r got %0d want 10", remainder); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || quotient !== 16'd30 || remainder !== 16'd10 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b q=%0d r=%0d z=%b want v=1 q=30 r=10 z=0", c, out_valid, quotient, remainder, div_by_zero);
         end
      end
      in_valid = 1'b0;
      take();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      int edges, busy, spur;
      send(16'd500, 16'd9);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'h0 || remainder !== 16'h0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL midreset_outputs got v=%b rdy=%b q=%h r=%h z=%b want v=0 rdy=1 q=0 r=0 z=0", out_valid, in_ready, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      spur = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) spur++;
      end
      checks++; if (spur != 0) begin errors++; $display("FAIL midreset_spurious_valid got %0d want 0", spur); end
      send(16'd81, 16'd9);
      wait_result(edges, busy);
      checks++; if (edges != LAT) begin errors++; $display("FAIL midreset_latency got %0d want %0d", edges, LAT); end
      checks++; if (quotient !== 16'd9) begin errors++; $display("FAIL midreset_q got %0d want 9", quotient); end
      checks++; if (remainder !== 16'd0) begin errors++; $display("FAIL midreset_r got %0d want 0", remainder); end
      take();
   endtask

`ifdef DIVIDER_SIGNED_EN
   task automatic test_signed();
      logic [WIDTH-1:0] vec [3][4] = '{
         '{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF},
         '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000},
         '{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001}
      };
      int edges, busy;
      for (int i = 0; i < 3; i++) begin
         send(vec[i][0], vec[i][1]);
         wait_result(edges, busy);
         checks++; if (edges != LAT) begin errors++; $display("FAIL signed%0d_latency got %0d want %0d", i, edges, LAT); end
         checks++; if (quotient !== vec[i][2]) begin errors++; $display("FAIL signed%0d_q got %h want %h", i, quotient, vec[i][2]); end
         checks++; if (remainder !== vec[i][3]) begin errors++; $display("FAIL signed%0d_r got %h want %h", i, remainder, vec[i][3]); end
         checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL signed%0d_dbz got %b want 0", i, div_by_zero); end
         take();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_div_zero();
      test_backpressure();
      test_reset_mid();
`ifdef DIVIDER_SIGNED_EN
      test_signed();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
